// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD bus capture block.
// Frame geometry defaults and pixel polarity live here so every file agrees.
package lcd_rx_pkg;

    typedef enum logic {
        WAIT_FP = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam int DEF_H_PIXELS = 160;
    localparam int DEF_V_LINES  = 80;
    localparam int CNT_W        = 16;

    // A dark pixel is driven as DO = 1 and stored as a 1 bit.
    localparam logic PIXEL_DARK = 1'b1;

    function automatic int bytes_per_line(input int h_pixels);
        return h_pixels / 8;
    endfunction

    localparam int BYTES_PER_LINE = bytes_per_line(DEF_H_PIXELS);

endpackage

// File: rtl/lcd_rx_edge.sv
// Input synchronizer chain followed by a one-flop rising-edge detector.
// The rise output is combinational from the last sync stage and the history flop.
module lcd_rx_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage
            // samples the value its neighbour held before this edge.
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/lcd_rx_capture.sv
// Rebuilds LCD serial frames as packed bytes for a shadow framebuffer and
// checks line length, line count, CKV count and FM alternation.
module lcd_rx_capture
    import lcd_rx_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lcd_CP,
    input  logic              lcd_DO,
    input  logic              lcd_FP,
    input  logic              lcd_LP,
    input  logic              lcd_FM,
    input  logic              lcd_CKV,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic              synced
);

    localparam logic [CNT_W-1:0]  H_CNT = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0]  V_CNT = CNT_W'(V_LINES);
    localparam logic [ADDR_W-1:0] BPL   = ADDR_W'(bytes_per_line(H_PIXELS));

    logic cp_rise, lp_rise, fp_rise, ckv_rise;
    logic [SYNC_STAGES-1:0] do_chain, fm_chain;

    lcd_rx_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cp  (.clk(clk), .reset(reset), .din(lcd_CP),  .rise(cp_rise));
    lcd_rx_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lp  (.clk(clk), .reset(reset), .din(lcd_LP),  .rise(lp_rise));
    lcd_rx_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fp  (.clk(clk), .reset(reset), .din(lcd_FP),  .rise(fp_rise));
    lcd_rx_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ckv (.clk(clk), .reset(reset), .din(lcd_CKV), .rise(ckv_rise));

    // Event register: edges and levels enter the FSM aligned in the same cycle.
    logic cp_ev, lp_ev, fp_ev, ckv_ev, do_ev, fm_ev;

    state_t              state, state_n;
    logic [CNT_W-1:0]    row, row_n, pix, pix_n, ckv_cnt, ckv_n;
    logic [ADDR_W-1:0]   col, col_n, base, base_n;
    logic [2:0]          bit_cnt, bit_n;
    logic [7:0]          shreg, shreg_n;
    logic                fm_lat, fm_lat_n, err_seen, err_seen_n;

    logic                wr_p, wr_p_n, line_err_p, line_err_p_n;
    logic                done_p, done_p_n, ferr_p, ferr_p_n;
    logic [ADDR_W-1:0]   addr_p, addr_p_n;
    logic [7:0]          data_p, data_p_n;
    logic                px_bit;

    assign px_bit = (do_ev == PIXEL_DARK);
    assign synced = (state == CAPTURE);

    always_comb begin
        // NOTE: every combinational output is given a default first so no path
        // through the case/if tree can infer a latch.
        state_n      = state;
        row_n        = row;
        pix_n        = pix;
        ckv_n        = ckv_cnt;
        col_n        = col;
        base_n       = base;
        bit_n        = bit_cnt;
        shreg_n      = shreg;
        fm_lat_n     = fm_lat;
        err_seen_n   = err_seen;
        wr_p_n       = 1'b0;
        addr_p_n     = addr_p;
        data_p_n     = data_p;
        line_err_p_n = 1'b0;
        done_p_n     = 1'b0;
        ferr_p_n     = 1'b0;

        case (state)
            WAIT_FP: begin
                if (fp_ev) begin
                    state_n    = CAPTURE;
                    row_n      = '0;
                    pix_n      = '0;
                    ckv_n      = '0;
                    col_n      = '0;
                    base_n     = '0;
                    bit_n      = '0;
                    shreg_n    = '0;
                    fm_lat_n   = fm_ev;
                    err_seen_n = 1'b0;
                end
            end
            CAPTURE: begin
                // Same-cycle events resolve CP, then LP, then FP, each seeing
                // the previous one's results through the *_n values.
                if (cp_ev) begin
                    if (pix < H_CNT && row < V_CNT) begin
                        shreg_n = {shreg[6:0], px_bit};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr_p_n   = 1'b1;
                            addr_p_n = base + col;
                            data_p_n = {shreg[6:0], px_bit};
                            col_n    = col + 1'b1;
                        end
                    end
                    if (pix != '1) pix_n = pix + 1'b1;
                end
                if (ckv_ev && ckv_cnt != '1) ckv_n = ckv_cnt + 1'b1;
                if (lp_ev) begin
                    if (pix_n != H_CNT) begin
                        line_err_p_n = 1'b1;
                        err_seen_n   = 1'b1;
                    end
                    if (row <= V_CNT) row_n = row + 1'b1;
                    if (row < V_CNT) base_n = base + BPL;
                    col_n   = '0;
                    bit_n   = '0;
                    pix_n   = '0;
                    shreg_n = '0;
                end
                if (fp_ev) begin
                    if (row_n == V_CNT && !err_seen_n && fm_ev != fm_lat && ckv_n == V_CNT)
                        done_p_n = 1'b1;
                    else
                        ferr_p_n = 1'b1;
                    row_n      = '0;
                    pix_n      = '0;
                    ckv_n      = '0;
                    col_n      = '0;
                    base_n     = '0;
                    bit_n      = '0;
                    shreg_n    = '0;
                    fm_lat_n   = fm_ev;
                    err_seen_n = 1'b0;
                end
            end
            default: state_n = WAIT_FP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            do_chain   <= '0;
            fm_chain   <= '0;
            cp_ev      <= 1'b0;
            lp_ev      <= 1'b0;
            fp_ev      <= 1'b0;
            ckv_ev     <= 1'b0;
            do_ev      <= 1'b0;
            fm_ev      <= 1'b0;
            state      <= WAIT_FP;
            row        <= '0;
            pix        <= '0;
            ckv_cnt    <= '0;
            col        <= '0;
            base       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            fm_lat     <= 1'b0;
            err_seen   <= 1'b0;
            wr_p       <= 1'b0;
            addr_p     <= '0;
            data_p     <= '0;
            line_err_p <= 1'b0;
            done_p     <= 1'b0;
            ferr_p     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            do_chain[0] <= lcd_DO;
            fm_chain[0] <= lcd_FM;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                do_chain[i] <= do_chain[i-1];
                fm_chain[i] <= fm_chain[i-1];
            end
            cp_ev      <= cp_rise;
            lp_ev      <= lp_rise;
            fp_ev      <= fp_rise;
            ckv_ev     <= ckv_rise;
            do_ev      <= do_chain[SYNC_STAGES-1];
            fm_ev      <= fm_chain[SYNC_STAGES-1];
            state      <= state_n;
            row        <= row_n;
            pix        <= pix_n;
            ckv_cnt    <= ckv_n;
            col        <= col_n;
            base       <= base_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            fm_lat     <= fm_lat_n;
            err_seen   <= err_seen_n;
            wr_p       <= wr_p_n;
            addr_p     <= addr_p_n;
            data_p     <= data_p_n;
            line_err_p <= line_err_p_n;
            done_p     <= done_p_n;
            ferr_p     <= ferr_p_n;
            wr_en      <= wr_p;
            wr_addr    <= addr_p;
            wr_data    <= data_p;
            line_err   <= line_err_p;
            frame_done <= done_p;
            frame_err  <= ferr_p;
        end
    end

endmodule

// File: tb/tb_lcd_rx_capture.sv
// Directed bench for lcd_rx_capture: full frames, short line, FM fault,
// simultaneous CP/LP/FP closure and mid-frame reset.
module tb_lcd_rx_capture;

    localparam int H  = 160;
    localparam int V  = 80;
    localparam int S  = 2;
    localparam int AW = 11;
    localparam int BPL_TB = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          lcd_CP, lcd_DO, lcd_FP, lcd_LP, lcd_FM, lcd_CKV;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done, line_err, frame_err, synced;

    lcd_rx_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(S), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .lcd_CP(lcd_CP), .lcd_DO(lcd_DO), .lcd_FP(lcd_FP), .lcd_LP(lcd_LP),
        .lcd_FM(lcd_FM), .lcd_CKV(lcd_CKV),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
        .synced(synced)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Write log and pulse counters, sampled on the falling edge.
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int            wc_q[$];
    int            fd_cnt = 0, fe_cnt = 0, le_cnt = 0;
    int            cp8_cyc = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (frame_err === 1'b1)  fe_cnt++;
        if (line_err === 1'b1)   le_cnt++;
    end

    function automatic logic px(input int mode, input int row, input int p);
        logic [7:0] pat;
        pat = 8'b1010_0001;
        case (mode)
            0: return 1'b1;
            1: return (row == 0 && p < 8) ? pat[7-p] : 1'b0;
            default: return ((row * 5 + p * 3 + p / 7) % 4) == 1;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int row, input int b);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = px(mode, row, b * 8 + k);
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input int mode, input int row, input int npix,
                             input logic lp_last, input logic fp_last);
        for (int p = 0; p < npix; p++) begin
            lcd_DO = px(mode, row, p);
            lcd_CP = 1'b1;
            if (p == 7) cp8_cyc = cyc;
            if (p == npix - 1) begin
                lcd_LP  = lp_last;
                lcd_CKV = lp_last;
                lcd_FP  = fp_last;
            end
            @(negedge clk);
            lcd_CP  = 1'b0;
            lcd_LP  = 1'b0;
            lcd_CKV = 1'b0;
            lcd_FP  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_fp();
        lcd_FP = 1'b1;
        @(negedge clk);
        lcd_FP = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int b;
        reset = 1'b1;
        idle(4);
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, line_err, frame_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h fd=%b le=%b fe=%b required all 0",
                     wr_en, wr_addr, wr_data, frame_done, line_err, frame_err);
        end
        checks++;
        if (synced !== 1'b0) begin
            failures++;
            $display("FAIL reset_synced: got %b required 0", synced);
        end
        reset = 1'b0;
        b = wa_q.size();
        send_line(0, 0, 20, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (wa_q.size() - b !== 0 || le_cnt !== 0) begin
            failures++;
            $display("FAIL wait_fp_ignores_cp_lp: got writes=%0d line_err=%0d required 0 and 0",
                     wa_q.size() - b, le_cnt);
        end
        checks++;
        if (synced !== 1'b0) begin
            failures++;
            $display("FAIL wait_fp_synced: got %b required 0", synced);
        end
    endtask

    // All-ones frame whose last pixel coincides with LP and the closing FP.
    task automatic test_full_frame();
        int b, fd0, fe0, le0, bad;
        b = wa_q.size(); fd0 = fd_cnt; fe0 = fe_cnt; le0 = le_cnt;
        send_fp();
        for (int r = 0; r < V; r++) begin
            if (r == V - 1) lcd_FM = 1'b1;
            send_line(0, r, H, 1'b1, r == V - 1);
        end
        idle(10);
        checks++;
        if (wa_q.size() - b !== 1600) begin
            failures++;
            $display("FAIL f1_write_count: got %0d required 1600", wa_q.size() - b);
        end
        bad = -1;
        for (int i = 0; i < 1600 && b + i < wa_q.size(); i++)
            if (bad < 0 && (wa_q[b+i] !== AW'(i) || wd_q[b+i] !== 8'hFF)) bad = i;
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL f1_addr_data: write %0d got addr=%0d data=%h required addr=%0d data=ff",
                     bad, wa_q[b+bad], wd_q[b+bad], bad);
        end
        checks++;
        if (wa_q.size() - b < 1600 || wa_q[b+1599] !== AW'(1599)) begin
            failures++;
            $display("FAIL f1_last_addr: write count %0d, last byte must go to addr 1599",
                     wa_q.size() - b);
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            failures++;
            $display("FAIL f1_frame_done: got %0d pulses required 1", fd_cnt - fd0);
        end
        checks++;
        if (fe_cnt - fe0 !== 0 || le_cnt - le0 !== 0) begin
            failures++;
            $display("FAIL f1_no_errors: got frame_err=%0d line_err=%0d required 0 and 0",
                     fe_cnt - fe0, le_cnt - le0);
        end
        checks++;
        if (synced !== 1'b1) begin
            failures++;
            $display("FAIL f1_synced: got %b required 1", synced);
        end
    endtask

    // Pattern on line 0, short line 5, then an early FP.
    task automatic test_pattern_short_line();
        int b, fd0, fe0, le0, bad, lat_ref;
        logic [7:0] want;
        b = wa_q.size(); fd0 = fd_cnt; fe0 = fe_cnt; le0 = le_cnt;
        send_line(1, 0, H, 1'b1, 1'b0);
        lat_ref = cp8_cyc;
        for (int r = 1; r < 5; r++) send_line(1, r, H, 1'b1, 1'b0);
        send_line(1, 5, 157, 1'b1, 1'b0);
        idle(4);
        lcd_FM = 1'b0;
        idle(6);
        send_fp();
        idle(10);
        checks++;
        if (wa_q.size() - b !== 119) begin
            failures++;
            $display("FAIL f2_write_count: got %0d required 119", wa_q.size() - b);
        end
        if (wa_q.size() > b) begin
            checks++;
            if (wa_q[b] !== AW'(0)) begin
                failures++;
                $display("FAIL next_frame_addr0: got %0d required 0", wa_q[b]);
            end
            checks++;
            if (wd_q[b] !== 8'hA1) begin
                failures++;
                $display("FAIL pattern_a1: got %h required a1", wd_q[b]);
            end
            checks++;
            if (wc_q[b] - (lat_ref + 1) !== S + 2) begin
                failures++;
                $display("FAIL latency: got %0d cycles required %0d", wc_q[b] - (lat_ref + 1), S + 2);
            end
        end else begin
            checks++;
            failures++;
            $display("FAIL f2_first_write: got 0 writes required at least 1");
        end
        bad = -1;
        for (int i = 0; i < 119 && b + i < wa_q.size(); i++) begin
            want = (i == 0) ? 8'hA1 : 8'h00;
            if (bad < 0 && (wa_q[b+i] !== AW'(i) || wd_q[b+i] !== want)) bad = i;
        end
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL f2_addr_data: write %0d got addr=%0d data=%h required addr=%0d",
                     bad, wa_q[b+bad], wd_q[b+bad], bad);
        end
        checks++;
        if (le_cnt - le0 !== 1) begin
            failures++;
            $display("FAIL short_line_err: got %0d pulses required 1", le_cnt - le0);
        end
        checks++;
        if (fe_cnt - fe0 !== 1 || fd_cnt - fd0 !== 0) begin
            failures++;
            $display("FAIL f2_frame_close: got frame_err=%0d frame_done=%0d required 1 and 0",
                     fe_cnt - fe0, fd_cnt - fd0);
        end
    endtask

    // FM left unchanged since the previous FP: data still lands, frame is rejected.
    task automatic test_fm_constant();
        int b, fd0, fe0, le0, bad;
        b = wa_q.size(); fd0 = fd_cnt; fe0 = fe_cnt; le0 = le_cnt;
        for (int r = 0; r < V; r++) send_line(2, r, H, 1'b1, 1'b0);
        idle(4);
        send_fp();
        idle(10);
        checks++;
        if (wa_q.size() - b !== 1600) begin
            failures++;
            $display("FAIL f3_write_count: got %0d required 1600", wa_q.size() - b);
        end
        bad = -1;
        for (int i = 0; i < 1600 && b + i < wa_q.size(); i++)
            if (bad < 0 && (wa_q[b+i] !== AW'(i) ||
                            wd_q[b+i] !== exp_byte(2, i / BPL_TB, i % BPL_TB))) bad = i;
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL f3_addr_data: write %0d got addr=%0d data=%h required addr=%0d data=%h",
                     bad, wa_q[b+bad], wd_q[b+bad], bad, exp_byte(2, bad / BPL_TB, bad % BPL_TB));
        end
        checks++;
        if (fe_cnt - fe0 !== 1 || fd_cnt - fd0 !== 0) begin
            failures++;
            $display("FAIL fm_constant: got frame_err=%0d frame_done=%0d required 1 and 0",
                     fe_cnt - fe0, fd_cnt - fd0);
        end
        checks++;
        if (le_cnt - le0 !== 0) begin
            failures++;
            $display("FAIL f3_line_err: got %0d required 0", le_cnt - le0);
        end
    endtask

    task automatic test_reset_mid_line();
        int b, p0;
        for (int r = 0; r < 40; r++) send_line(0, r, H, 1'b1, 1'b0);
        send_line(0, 40, 50, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, line_err, frame_err, synced} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got wr_en=%b addr=%0d data=%h fd=%b le=%b fe=%b synced=%b required all 0",
                     wr_en, wr_addr, wr_data, frame_done, line_err, frame_err, synced);
        end
        b = wa_q.size();
        p0 = fd_cnt + fe_cnt + le_cnt;
        send_line(0, 40, 110, 1'b1, 1'b0);
        send_line(0, 41, H, 1'b1, 1'b0);
        idle(6);
        checks++;
        if (wa_q.size() - b !== 0 || fd_cnt + fe_cnt + le_cnt - p0 !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got writes=%0d pulses=%0d required 0 and 0",
                     wa_q.size() - b, fd_cnt + fe_cnt + le_cnt - p0);
        end
        checks++;
        if (synced !== 1'b0) begin
            failures++;
            $display("FAIL midreset_synced: got %b required 0", synced);
        end
        send_fp();
        send_line(0, 0, 16, 1'b0, 1'b0);
        idle(8);
        checks++;
        if (synced !== 1'b1) begin
            failures++;
            $display("FAIL restart_synced: got %b required 1", synced);
        end
        checks++;
        if (wa_q.size() - b !== 2) begin
            failures++;
            $display("FAIL restart_write_count: got %0d required 2", wa_q.size() - b);
        end else begin
            checks++;
            if (wa_q[b] !== AW'(0) || wd_q[b] !== 8'hFF || wa_q[b+1] !== AW'(1)) begin
                failures++;
                $display("FAIL restart_addr: got addr=%0d data=%h next=%0d required 0 ff 1",
                         wa_q[b], wd_q[b], wa_q[b+1]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        lcd_CP  = 1'b0;
        lcd_DO  = 1'b0;
        lcd_FP  = 1'b0;
        lcd_LP  = 1'b0;
        lcd_FM  = 1'b0;
        lcd_CKV = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_pattern_short_line();
        test_fm_constant();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_rx_capture.md
Name: lcd_rx_capture

Overview:
- Downstream of the LCD pump. Samples the serial LCD bus (CP, DO, FP, LP, FM, CKV) and rebuilds the frame as packed bytes.
- Bytes go out on a simple write port into a shadow framebuffer, used by host-side display and bench scoreboarding.
- Checks bus protocol integrity: line length, line count and FM alternation.
- Runs on the same fast clock as the pump (clk4x domain). Input synchronizers are kept so the block can also sit behind a real panel connector.

Parameters:
- H_PIXELS, 160, pixels per line; must be a multiple of 8.
- V_LINES, 80, lines per frame.
- SYNC_STAGES, 2, flops per input synchronizer; minimum 1.
- ADDR_W, 11, write-address width; must satisfy 2**ADDR_W >= H_PIXELS*V_LINES/8.

Ports:
- clk  in  1  capture clock, clk4x domain.
- reset  in  1  synchronous, active-high reset.
- lcd_CP  in  1  pixel clock; a pixel is taken on each rising edge.
- lcd_DO  in  1  pixel data; 1 = dark.
- lcd_FP  in  1  frame pulse; a rising edge marks start of frame.
- lcd_LP  in  1  line pulse; a rising edge closes the current line.
- lcd_FM  in  1  AC-drive polarity; must toggle once per frame.
- lcd_CKV  in  1  row clock; its rising edges are counted only.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  byte address = row*(H_PIXELS/8) + byte column.
- wr_data  out  8  packed pixels; leftmost pixel in bit 7.
- frame_done  out  1  one-cycle pulse when a complete, error-free frame is closed.
- line_err  out  1  one-cycle pulse when a line closes with a pixel count other than H_PIXELS.
- frame_err  out  1  one-cycle pulse when the frame line count is not V_LINES, or on an FM or CKV mismatch.
- synced  out  1  high while in CAPTURE.

Behaviour:
- All inputs pass through SYNC_STAGES flops, then a 1-flop edge detector. Only synchronized rising edges act; levels are ignored except FM.
- Reset: all outputs are 0 and the FSM enters WAIT_FP. The shift register, counters and the stored FM value are cleared.
- Reset asserted mid-frame aborts at once. No write happens in the cycle after reset is released.
- FSM states:
  - WAIT_FP: ignore CP and LP. On FP rise go to CAPTURE, with row=0, col=0, bit=0, base=0, and FM latched.
  - CAPTURE:
    - CP rise: shift DO into bit 0 of the shift register (MSB-first packing) and increment bit/pixel.
    - On the 8th bit: wr_en=1, wr_data=the byte, wr_addr=base+col; then col increments. Writes stop once the pixel count reaches H_PIXELS; extra CP edges are counted but not written.
    - LP rise: if pixel count != H_PIXELS, pulse line_err and drop any partial byte. Then row increments, base += H_PIXELS/8, and col, bit and pixel reset.
    - When row reaches V_LINES, further lines are not written and the frame is flagged over-length.
    - FP rise:
      - Frame OK = row == V_LINES, no line_err this frame, FM != latched FM, and CKV edge count == V_LINES. OK pulses frame_done; otherwise pulses frame_err.
      - Then restart at row 0, latch the new FM, and stay in CAPTURE.
- Latency: wr_en is asserted exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples the 8th pixel's CP high.
- Throughput: CP high and low phases must each be ≥ 1 clk. Faster CP is undefined.
- Simultaneous synchronized events, in one cycle, are processed in this order: CP, then LP, then FP. The pixel counts in the old line, the line closes, then the frame closes.
- Address arithmetic uses a running base adder; no multiplier.
  - base is ADDR_W bits and never wraps within a frame, because rows ≥ V_LINES are not written.
- Outputs are registered. Pulses last exactly 1 cycle.

Decomposition:
- Shared package lcd_rx_pkg:
  - State enum {WAIT_FP, CAPTURE}.
  - Default H_PIXELS / V_LINES.
  - Localparam BYTES_PER_LINE = H_PIXELS/8.
  - Pixel polarity constant (1 = dark).
- Sub-module lcd_rx_edge: one synchronizer chain plus rising-edge detector, SYNC_STAGES parameter. Instantiated for CP, LP, FP and CKV. FM and DO use the synchronizer only.

Test Plan:
- Reset, then a full 160x80 frame with all-ones DO, FM toggling, 80 CKV edges, then an FP rise:
  - 1600 writes, addresses 0..1599 in order, every wr_data=0xFF.
  - One frame_done; no errors.
- Line 0 pixel pattern 1,0,1,0,0,0,0,1 then zeros:
  - First write is addr 0, data 0xA1.
  - Latency is exactly SYNC_STAGES+2 cycles from the 8th CP sample.
- Line 5 closed after 157 CP edges:
  - line_err pulses once; 19 writes for that line (addr 100..118).
  - At the next FP: frame_err pulses, frame_done stays 0.
- CP, LP and FP rise in the same sample cycle after the 159th pixel of line 79:
  - 160th pixel included; final byte written to addr 1599.
  - frame_done pulses; the next write after that is addr 0.
- FM held constant across two frames:
  - Second FP gives frame_err and no frame_done; the data writes are still correct.
- Reset asserted mid-line 40 for 1 cycle:
  - Outputs go to 0 and synced=0; no writes until the next FP rise.
  - After that FP rise, capture restarts at addr 0.
